// File: rtl/vip_matrix_3x3_gen_8bit.sv
// -----------------------------------------------------------------------------
// vip_matrix_3x3_gen_8bit
//
// Purpose:
//   Turns the three row taps of the upstream two-line shift buffer into a
//   3x3 pixel neighbourhood for Sobel, median, erosion/dilation and similar
//   filters. Three 3-deep column shift registers hold the window. Rows that
//   are not yet valid in the current frame are masked to zero. Each line
//   starts from zero left padding. Frame row/column position is tracked, and
//   lines whose pixel count differs from IMG_HDISP are flagged.
//
// Optional feature (compile-time macro MATRIX_INTERIOR_ONLY_EN):
//   When the macro is defined, post_frame_clken marks only windows whose nine
//   pixels are all real image pixels. This needs column index >= 2 and row
//   index >= 2. Window data is the same in both builds.
//
// Parameters:
//   IMG_HDISP  active pixels per line
//   IMG_VDISP  active lines per frame
//   DATA_W     pixel width in bits
//
// Ports:
//   clock                  system clock, all logic on rising edge
//   reset                  synchronous, active-high reset
//   per_frame_vsync        frame sync, high during frame, aligned with taps
//   per_frame_href         line valid, aligned with taps
//   per_frame_clken        pixel strobe, aligned with taps
//   taps0x/taps1x/taps2x   pixels from rows y-2 (oldest), y-1, y (current)
//   post_frame_vsync       per_frame_vsync delayed by 1 cycle
//   post_frame_href        per_frame_href delayed by 1 cycle
//   post_frame_clken       window-valid strobe, 1 cycle after the pixel strobe
//   matrix_p11..p13        top row of the window, oldest to newest column
//   matrix_p21..p23        middle row of the window
//   matrix_p31..p33        bottom row of the window (row y)
//   line_len_err           sticky; a line ended with a wrong pixel count
// -----------------------------------------------------------------------------
module vip_matrix_3x3_gen_8bit #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int DATA_W    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] taps0x,
    input  logic [DATA_W-1:0] taps1x,
    input  logic [DATA_W-1:0] taps2x,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33,
    output logic              line_len_err
);

    localparam int COL_W = $clog2(IMG_HDISP) + 1;
    localparam int ROW_W = $clog2(IMG_VDISP + 1);

    localparam logic [COL_W-1:0] COL_MAX   = {COL_W{1'b1}};
    localparam logic [COL_W-1:0] COL_HDISP = COL_W'(IMG_HDISP);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IMG_VDISP);

    // Edge-detect history and frame arming
    logic              vsync_d_r;
    logic              href_d_r;
    logic              low_seen_r;   // vsync seen low since reset, so a rise is genuine
    logic              armed_r;      // a frame start has been seen since reset

    // Position counters
    logic [COL_W-1:0]  col_cnt_r;
    logic [ROW_W-1:0]  row_cnt_r;

    // Window registers
    logic [DATA_W-1:0] p11_r, p12_r, p13_r;
    logic [DATA_W-1:0] p21_r, p22_r, p23_r;
    logic [DATA_W-1:0] p31_r, p32_r, p33_r;

    // Registered outputs
    logic              post_vsync_r;
    logic              post_href_r;
    logic              post_clken_r;
    logic              line_len_err_r;

    // Combinational control
    logic              frame_start_s;
    logic              active_s;
    logic              href_rise_s;
    logic              href_fall_s;
    logic              pix_s;
    logic [ROW_W-1:0]  row_eff_s;
    logic [COL_W-1:0]  col_next_s;
    logic [DATA_W-1:0] tap0_m_s;
    logic [DATA_W-1:0] tap1_m_s;
    logic [DATA_W-1:0] tap2_m_s;
    logic              window_ok_s;

    // Frame/line event decode. The logic is active from the first genuine
    // vsync rise after reset onward.
    always_comb begin
        frame_start_s = per_frame_vsync & ~vsync_d_r & low_seen_r;
        active_s      = armed_r | frame_start_s;
        href_rise_s   = active_s & per_frame_href & ~href_d_r;
        href_fall_s   = active_s & ~per_frame_href & href_d_r;
        pix_s         = active_s & per_frame_href & per_frame_clken;
        // A frame start in this very cycle means the row counter is about to clear.
        if (frame_start_s) begin
            row_eff_s = {ROW_W{1'b0}};
        end else begin
            row_eff_s = row_cnt_r;
        end
    end

    // Next column count. A strobe on the line-start cycle already counts
    // as pixel 1. The count saturates instead of wrapping.
    always_comb begin
        col_next_s = col_cnt_r;
        if (href_rise_s) begin
            if (per_frame_clken) begin
                col_next_s = COL_W'(1);
            end else begin
                col_next_s = {COL_W{1'b0}};
            end
        end else if (pix_s && (col_cnt_r != COL_MAX)) begin
            col_next_s = col_cnt_r + COL_W'(1);
        end else begin
            col_next_s = col_cnt_r;
        end
    end

    // Zero the rows above the top of the frame before they enter the window.
    always_comb begin
        tap0_m_s = taps0x;
        tap1_m_s = taps1x;
        tap2_m_s = taps2x;
        case (row_eff_s)
            ROW_W'(0): begin
                tap0_m_s = {DATA_W{1'b0}};
                tap1_m_s = {DATA_W{1'b0}};
            end
            ROW_W'(1): begin
                tap0_m_s = {DATA_W{1'b0}};
            end
            default: begin
                tap0_m_s = taps0x;
                tap1_m_s = taps1x;
            end
        endcase
    end

    // Window-valid qualification for the delayed strobe
    always_comb begin
        window_ok_s = 1'b0;
`ifdef MATRIX_INTERIOR_ONLY_EN
        if (pix_s && (col_next_s >= COL_W'(3)) && (row_eff_s >= ROW_W'(2))) begin
            window_ok_s = 1'b1;
        end else begin
            window_ok_s = 1'b0;
        end
`else
        window_ok_s = pix_s;
`endif
    end

    // Input history for edge detection and frame arming
    always_ff @(posedge clock) begin
        if (reset) begin
            vsync_d_r  <= 1'b0;
            href_d_r   <= 1'b0;
            low_seen_r <= ~per_frame_vsync;
            armed_r    <= 1'b0;
        end else begin
            vsync_d_r  <= per_frame_vsync;
            href_d_r   <= per_frame_href;
            low_seen_r <= low_seen_r | ~per_frame_vsync;
            armed_r    <= active_s;
        end
    end

    // Column and row position counters
    always_ff @(posedge clock) begin
        if (reset) begin
            col_cnt_r <= {COL_W{1'b0}};
            row_cnt_r <= {ROW_W{1'b0}};
        end else begin
            col_cnt_r <= col_next_s;
            if (frame_start_s) begin
                row_cnt_r <= {ROW_W{1'b0}};
            end else if (href_fall_s && (row_cnt_r != ROW_MAX)) begin
                row_cnt_r <= row_cnt_r + ROW_W'(1);
            end
        end
    end

    // 3x3 column shift registers. Each line starts from an all-zero window,
    // so the leftmost windows get zero padding.
    always_ff @(posedge clock) begin
        if (reset) begin
            p11_r <= {DATA_W{1'b0}}; p12_r <= {DATA_W{1'b0}}; p13_r <= {DATA_W{1'b0}};
            p21_r <= {DATA_W{1'b0}}; p22_r <= {DATA_W{1'b0}}; p23_r <= {DATA_W{1'b0}};
            p31_r <= {DATA_W{1'b0}}; p32_r <= {DATA_W{1'b0}}; p33_r <= {DATA_W{1'b0}};
        end else if (href_rise_s) begin
            p11_r <= {DATA_W{1'b0}}; p12_r <= {DATA_W{1'b0}};
            p21_r <= {DATA_W{1'b0}}; p22_r <= {DATA_W{1'b0}};
            p31_r <= {DATA_W{1'b0}}; p32_r <= {DATA_W{1'b0}};
            if (per_frame_clken) begin
                p13_r <= tap0_m_s;
                p23_r <= tap1_m_s;
                p33_r <= tap2_m_s;
            end else begin
                p13_r <= {DATA_W{1'b0}};
                p23_r <= {DATA_W{1'b0}};
                p33_r <= {DATA_W{1'b0}};
            end
        end else if (pix_s) begin
            p11_r <= p12_r; p12_r <= p13_r; p13_r <= tap0_m_s;
            p21_r <= p22_r; p22_r <= p23_r; p23_r <= tap1_m_s;
            p31_r <= p32_r; p32_r <= p33_r; p33_r <= tap2_m_s;
        end
    end

    // Delayed sync/strobe outputs and the sticky line-length error.
    // A frame start has priority over setting the error.
    always_ff @(posedge clock) begin
        if (reset) begin
            post_vsync_r   <= 1'b0;
            post_href_r    <= 1'b0;
            post_clken_r   <= 1'b0;
            line_len_err_r <= 1'b0;
        end else begin
            post_vsync_r <= per_frame_vsync;
            post_href_r  <= per_frame_href;
            post_clken_r <= window_ok_s;
            if (frame_start_s) begin
                line_len_err_r <= 1'b0;
            end else if (href_fall_s && (col_cnt_r != COL_HDISP)) begin
                line_len_err_r <= 1'b1;
            end
        end
    end

    assign post_frame_vsync = post_vsync_r;
    assign post_frame_href  = post_href_r;
    assign post_frame_clken = post_clken_r;
    assign line_len_err     = line_len_err_r;
    assign matrix_p11 = p11_r;
    assign matrix_p12 = p12_r;
    assign matrix_p13 = p13_r;
    assign matrix_p21 = p21_r;
    assign matrix_p22 = p22_r;
    assign matrix_p23 = p23_r;
    assign matrix_p31 = p31_r;
    assign matrix_p32 = p32_r;
    assign matrix_p33 = p33_r;

endmodule

// File: doc/vip_matrix_3x3_gen_8bit.md
Name: vip_matrix_3x3_gen_8bit

Overview:
- Builds a 3x3 pixel window stream from the three row taps of the two-line shift buffer, which sits directly upstream.
- Feeds 3x3 neighbourhood filters: Sobel, median, erosion/dilation.
- Holds three 3-deep column shift registers and masks rows that are not yet valid in the current frame.
- Tracks frame row/column position and flags malformed lines.

Parameters:
IMG_HDISP, 640, active pixels per line
IMG_VDISP, 480, active lines per frame
DATA_W, 8, pixel width in bits

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
per_frame_vsync  in  1  frame sync, high during frame, aligned with taps
per_frame_href  in  1  line valid, aligned with taps
per_frame_clken  in  1  pixel strobe, aligned with taps
taps0x  in  DATA_W  pixel from row y-2 (oldest)
taps1x  in  DATA_W  pixel from row y-1
taps2x  in  DATA_W  pixel from row y (current)
post_frame_vsync  out  1  per_frame_vsync delayed 1 cycle
post_frame_href  out  1  per_frame_href delayed 1 cycle
post_frame_clken  out  1  window-valid strobe
matrix_p11..p13  out  DATA_W each  window top row, oldest column to newest (p13 = column x)
matrix_p21..p23  out  DATA_W each  window middle row
matrix_p31..p33  out  DATA_W each  window bottom row (row y)
line_len_err  out  1  sticky: a line ended with a pixel count other than IMG_HDISP

Behaviour:
- Reset: all outputs 0, all counters 0, all shift registers 0.
- Reset mid-frame: outputs return to 0 at once. Counting resumes only at the next vsync rising edge; windows are suppressed until then.
- Edge detect: vsync and href are registered. A vsync rise marks frame start. An href rise marks line start and an href fall marks line end.
- Column counter col_cnt:
  - Width log2(IMG_HDISP)+1.
  - Cleared on href rise.
  - Increments on each per_frame_clken while href is high.
  - Saturates at all-ones; no wrap.
- Row counter row_cnt:
  - Cleared on vsync rise.
  - Increments on each href fall.
  - Saturates at IMG_VDISP.
- Row masking, applied to the taps before shifting:
  - row_cnt==0: taps0x and taps1x forced to 0.
  - row_cnt==1: taps0x forced to 0.
  - Otherwise the taps pass unmasked.
- Column shift, on per_frame_clken:
  - p13<=masked taps0x, p12<=p13, p11<=p12.
  - The same pattern applies to rows 2 and 3.
  - If per_frame_clken is low, the registers hold.
- Line-start clear:
  - On an href rise cycle, all nine registers clear to 0. This gives zero left padding.
  - If clken is also high in that cycle, only the p13/p23/p33 column loads and the rest stay 0.
- Latency:
  - 1 cycle from per_frame_clken to post_frame_clken.
  - Window contents at post_frame_clken correspond to the taps sampled on that strobe.
  - post_frame_vsync and post_frame_href are the 1-cycle-delayed inputs.
- Default window emission: post_frame_clken = per_frame_clken delayed 1, gated off while awaiting the first vsync after reset. This gives IMG_HDISP*IMG_VDISP windows per frame.
- line_len_err:
  - Set on an href fall when col_cnt != IMG_HDISP.
  - Cleared on vsync rise.
  - If set and clear occur in the same cycle, clear wins.
- clken while href is low: ignored. No shift, no count, no output strobe.

Optional Feature:
MATRIX_INTERIOR_ONLY_EN
- Defined:
  - post_frame_clken is asserted only for windows whose nine pixels are all real image pixels, i.e. col_cnt>=3 (after increment) and row_cnt>=2.
  - This gives (IMG_HDISP-2)*(IMG_VDISP-2) windows per frame.
  - Window data is unchanged.
- Undefined: every pixel strobe produces a window with zero padding, as in Behaviour.

Test Plan:
- Params 8x4. Reset high 3 cycles, then one frame with pixel value = 16*row+col -> all outputs 0 during reset; exactly 32 post_frame_clken pulses; first pulse has p33=0x00 and all others 0.
- Same frame, row 2 col 4 -> p11..p13=0x02,0x03,0x04; p21..p23=0x12,0x13,0x14; p31..p33=0x22,0x23,0x24.
- Row 1, first pixel -> p13=0, p23=0x00 (row 0 data), p33=0x10; p11,p12,p21,p22,p31,p32=0.
- Line with 7 clkens (HDISP=8) -> line_len_err=1 after that href fall, remains 1 through frame, returns 0 one cycle after next vsync rise.
- clken low for 5 cycles mid-line -> matrix holds; no post_frame_clken; resumes correctly; no line_len_err.
- MATRIX_INTERIOR_ONLY_EN defined, 8x4 frame -> exactly 12 pulses; first at row 2 col 2 with p11=0x00, p33=0x22.
